// File: rtl/sgd_pkg.sv
// Shared types and constants for the SGD label/feature dispatch slice.
package sgd_pkg;

  localparam int unsigned NUM_OF_BANKS = 8;
  localparam int unsigned BEAT_W       = 512;
  localparam int unsigned LABEL_W      = 32;
  localparam int unsigned HALF_W       = BEAT_W / 2;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    STREAM,
    FIN
  } sgd_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sgd_dispatch_b_if.sv
// Read-command, beat-stream and dispatch-FIFO signals of the label feeder.
interface sgd_dispatch_b_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LEN_W  = 32,
  parameter int unsigned DISP_W = 256
);

  logic              rd_cmd_valid;
  logic              rd_cmd_ready;
  logic [ADDR_W-1:0] rd_cmd_addr;
  logic [LEN_W-1:0]  rd_cmd_len;

  logic [511:0]      s_axis_b_data;
  logic              s_axis_b_valid;
  logic              s_axis_b_last;
  logic              s_axis_b_ready;

  logic [DISP_W-1:0] dispatch_axb_b_data;
  logic              dispatch_axb_b_wr_en;
  logic              dispatch_axb_b_almost_full;

  modport master (
    output rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
    input  rd_cmd_ready,
    input  s_axis_b_data, s_axis_b_valid, s_axis_b_last,
    output s_axis_b_ready,
    output dispatch_axb_b_data, dispatch_axb_b_wr_en,
    input  dispatch_axb_b_almost_full
  );

  modport slave (
    input  rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
    output rd_cmd_ready,
    output s_axis_b_data, s_axis_b_valid, s_axis_b_last,
    input  s_axis_b_ready,
    input  dispatch_axb_b_data, dispatch_axb_b_wr_en,
    output dispatch_axb_b_almost_full
  );

endinterface

// File: rtl/sgd_beat_splitter.sv
// Holds one 512-bit beat and emits it as two 256-bit halves, low half first.
module sgd_beat_splitter
  import sgd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BEAT_W-1:0] load_data,
  input  logic              almost_full,
  input  logic              grp_nz,
  input  logic              grp_one,
  output logic              beat_valid,
  output logic              wr_en,
  output logic              rel,
  output logic [HALF_W-1:0] wr_data
);

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              valid_q, valid_d;
  logic              hsel_q, hsel_d;

  assign beat_valid = valid_q;
  assign wr_en      = valid_q & ~almost_full & grp_nz;
  // Odd group counts finish on a low half; the unused high half is dropped.
  assign rel        = wr_en & (hsel_q | grp_one);
  assign wr_data    = hsel_q ? beat_q[BEAT_W-1:HALF_W] : beat_q[HALF_W-1:0];

  always_comb begin
    beat_d  = beat_q;
    valid_d = valid_q;
    hsel_d  = hsel_q;
    if (wr_en) begin
      if (rel) valid_d = 1'b0;
      else     hsel_d  = 1'b1;
    end
    if (load) begin
      beat_d  = load_data;
      valid_d = 1'b1;
      hsel_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q  <= '0;
      valid_q <= 1'b0;
      hsel_q  <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      valid_q <= valid_d;
      hsel_q  <= hsel_d;
    end
  end

endmodule

// File: rtl/sgd_dispatch_b.sv
// Label feeder: one read per epoch, beats split into 8-label dispatch words.
// Optional SGD_DISPATCH_B_STAT_EN adds saturating write and stall counters.
module sgd_dispatch_b
  import sgd_pkg::*;
#(
  parameter int unsigned NUM_OF_BANKS = 8,
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned LEN_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [31:0]       number_of_samples,
  input  logic [31:0]       number_of_epochs,
  sgd_dispatch_b_if.master  bus,
  output logic              done,
  output logic              err
`ifdef SGD_DISPATCH_B_STAT_EN
  ,
  output logic [31:0]       stat_wr_cnt,
  output logic [31:0]       stat_stall_cnt
`endif
);

  localparam int unsigned DISP_W = 32 * NUM_OF_BANKS;

  sgd_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [31:0]       groups_q, groups_d;
  logic [31:0]       beats_q, beats_d;
  logic [31:0]       epoch_left_q, epoch_left_d;
  logic [31:0]       grp_left_q, grp_left_d;
  logic [31:0]       beat_left_q, beat_left_d;
  logic              rd_cmd_valid_q, rd_cmd_valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [31:0]       grp_calc, beats_calc;
  logic              beat_valid, wr_en, rel, ready, beat_acc;
  logic [DISP_W-1:0] split_data;

  assign ready    = (state_q == STREAM) && (beat_left_q != 32'd0) && (!beat_valid || rel);
  assign beat_acc = ready && bus.s_axis_b_valid;

  sgd_beat_splitter u_split (
    .clk         (clk),
    .rst         (rst),
    .load        (beat_acc),
    .load_data   (bus.s_axis_b_data),
    .almost_full (bus.dispatch_axb_b_almost_full),
    .grp_nz      (grp_left_q != 32'd0),
    .grp_one     (grp_left_q == 32'd1),
    .beat_valid  (beat_valid),
    .wr_en       (wr_en),
    .rel         (rel),
    .wr_data     (split_data)
  );

  assign bus.rd_cmd_valid         = rd_cmd_valid_q;
  assign bus.rd_cmd_addr          = addr_q;
  assign bus.rd_cmd_len           = len_q;
  assign bus.s_axis_b_ready       = ready;
  assign bus.dispatch_axb_b_data  = split_data;
  assign bus.dispatch_axb_b_wr_en = wr_en;
  assign done                     = done_q;
  assign err                      = err_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    groups_d     = groups_q;
    beats_d      = beats_q;
    epoch_left_d = epoch_left_q;
    grp_left_d   = grp_left_q;
    beat_left_d  = beat_left_q;
    err_d        = err_q;
    grp_calc     = number_of_samples >> 3;
    beats_calc   = (grp_calc + 32'd1) >> 1;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d       = addr_b;
          groups_d     = grp_calc;
          beats_d      = beats_calc;
          len_d        = LEN_W'({beats_calc, 6'd0});
          epoch_left_d = number_of_epochs;
          state_d      = (grp_calc == 32'd0 || number_of_epochs == 32'd0) ? FIN : CMD;
        end
      end
      CMD: begin
        if (bus.rd_cmd_ready) begin
          grp_left_d  = groups_q;
          beat_left_d = beats_q;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (beat_acc) begin
          beat_left_d = beat_left_q - 32'd1;
          if (bus.s_axis_b_last != (beat_left_q == 32'd1)) err_d = 1'b1;
        end
        // The epoch ends on the cycle of its final write, so done follows it directly.
        if (wr_en) begin
          grp_left_d = grp_left_q - 32'd1;
          if (grp_left_q == 32'd1) begin
            epoch_left_d = epoch_left_q - 32'd1;
            state_d      = (epoch_left_q == 32'd1) ? FIN : CMD;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rd_cmd_valid_d = (state_d == CMD);
    done_d         = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      len_q          <= '0;
      groups_q       <= '0;
      beats_q        <= '0;
      epoch_left_q   <= '0;
      grp_left_q     <= '0;
      beat_left_q    <= '0;
      rd_cmd_valid_q <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      groups_q       <= groups_d;
      beats_q        <= beats_d;
      epoch_left_q   <= epoch_left_d;
      grp_left_q     <= grp_left_d;
      beat_left_q    <= beat_left_d;
      rd_cmd_valid_q <= rd_cmd_valid_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

`ifdef SGD_DISPATCH_B_STAT_EN
  logic [31:0] stat_wr_q, stat_wr_d;
  logic [31:0] stat_stall_q, stat_stall_d;
  logic        start_acc;

  assign start_acc      = (state_q == IDLE) && start;
  assign stat_wr_cnt    = stat_wr_q;
  assign stat_stall_cnt = stat_stall_q;

  always_comb begin
    stat_wr_d    = stat_wr_q;
    stat_stall_d = stat_stall_q;
    if (start_acc) begin
      stat_wr_d    = '0;
      stat_stall_d = '0;
    end else begin
      if (wr_en) stat_wr_d = sat_inc32(stat_wr_q);
      if (beat_valid && bus.dispatch_axb_b_almost_full) stat_stall_d = sat_inc32(stat_stall_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_wr_q    <= stat_wr_d;
      stat_stall_q <= stat_stall_d;
    end
  end
`endif

endmodule

// File: doc/sgd_dispatch_b.md
Name: sgd_dispatch_b

Overview:
Label (b) feeder for sgd_top_bw. For every epoch it issues one read command for the label array in memory. It then takes the returned 512-bit beats (16 × 32-bit labels each) and splits each beat into 256-bit groups of 8 labels. Each group is written into the dispatch_axb_b FIFO interface under almost_full flow control, so the b-side input is replayed exactly number_of_epochs times.

Parameters:
NUM_OF_BANKS, 8, labels per dispatch word; dispatch width = 32*NUM_OF_BANKS (must be 8).
ADDR_W, 64, memory address width.
LEN_W, 32, command length width in bytes.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle start pulse; sampled only in IDLE
addr_b  in  ADDR_W  byte base of label array, 64B aligned
number_of_samples  in  32  label count; multiple of 8
number_of_epochs  in  32  replay count
rd_cmd_valid  out  1  read command valid
rd_cmd_ready  in  1  read command accept
rd_cmd_addr  out  ADDR_W  = addr_b
rd_cmd_len  out  LEN_W  bytes = beats*64
s_axis_b_data  in  512  returned beat, label k at bits [32k+31:32k]
s_axis_b_valid  in  1  beat valid
s_axis_b_last  in  1  last beat of command
s_axis_b_ready  out  1  beat accept
dispatch_axb_b_data  out  32*NUM_OF_BANKS  8 labels
dispatch_axb_b_wr_en  out  1  FIFO write strobe
dispatch_axb_b_almost_full  in  1  FIFO almost full; one further write is tolerated
done  out  1  one-cycle pulse after final epoch
err  out  1  sticky tlast mismatch

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Derived values, latched at start:
  - groups = number_of_samples>>3
  - beats = (groups+1)>>1
  - epoch_left = number_of_epochs
- Reset: state=IDLE. rd_cmd_valid, s_axis_b_ready, dispatch_axb_b_wr_en, done and err all 0. The beat register is emptied.
- Reset mid-operation: any held beat is dropped and no partial write is issued. Upstream data still in flight after reset is the system's responsibility to flush.
- States:
  - IDLE: on start, go to CMD, or to FIN if groups==0 or epochs==0. start outside IDLE is ignored.
  - CMD: rd_cmd_valid=1, held stable until rd_cmd_ready. On handshake, go to STREAM with grp_left=groups and beat_left=beats.
  - STREAM: consume beats and write groups. When grp_left reaches 0, decrement epoch_left and go to CMD if it is non-zero, else FIN.
  - FIN: done=1 for one cycle, then IDLE.
- Beat register: holds one 512-bit beat plus a half selector hsel (0 = low 256 bits first).
- dispatch_axb_b_wr_en = beat_valid && ~almost_full && grp_left!=0. This path is combinational from almost_full.
- dispatch_axb_b_data = hsel ? beat[511:256] : beat[255:0].
- On each write, grp_left is decremented. The beat is released when hsel==1 was written, or when hsel==0 was written and grp_left==1 (odd group count; the high half is discarded).
- s_axis_b_ready = STREAM && beat_left!=0 && (~beat_valid || release_this_cycle). This bypass sustains one write per cycle with no bubble.
- tlast check: if s_axis_b_last is accepted while beat_left!=1, or is absent when beat_left==1, err is set. err clears only on rst. Data is still consumed normally.
- Stall: almost_full high freezes grp_left, hsel and the beat. s_axis_b_ready falls once the register is full.
- Simultaneous release and new beat in the same cycle: the new beat loads with hsel=0.

Optional Feature:
SGD_DISPATCH_B_STAT_EN
- With the macro: adds output stat_wr_cnt[31:0] (total writes) and stat_stall_cnt[31:0] (cycles with beat_valid && almost_full). Both clear on rst and on start, and saturate at all-ones.
- Without the macro: neither port nor its logic exists.

Decomposition:
- Shared package sgd_pkg: NUM_OF_BANKS, BEAT_W=512, LABEL_W=32, and the state enum typedef {IDLE,CMD,STREAM,FIN}.
- One natural sub-module: sgd_beat_splitter. It holds the beat register, hsel and the release logic, and is reused for the a-side if needed. The FSM and counters stay in the top level.

Test Plan:
- Basic run: samples=32, epochs=1, almost_full=0, 2 beats → cmd len=128, addr=addr_b; 4 writes of labels 0..31 in order; done pulses 1 cycle after the last write.
- Replay: samples=72320, epochs=3 → 3 commands; 27120 writes total; label 0 reappears at writes 9040 and 18080.
- Odd group count: samples=24 → 2 beats, 3 writes; beat1 high half never written; len=128.
- Backpressure: toggle almost_full at random 50% → no write while almost_full=1; data order identical to the no-stall run; no beat lost.
- Protocol error: tlast on beat 1 of 2 → err=1 and stays 1; write count still 4.
- Reset mid-stream: assert rst after 3 writes → all outputs 0 next cycle; a new start yields a clean full sequence.
